// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin front end for a shared combinational ALU.
// One transaction is in flight at a time: accept in IDLE, launch registered
// operands, wait SETTLE cycles in EXEC, then hold the captured result in RESP
// until the owning port takes it.
module alu_arbiter #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2:0]       req_op0,
    input  logic [2:0]       req_op1,
    input  logic             req_c0,
    input  logic             req_c1,
    input  logic [WIDTH-1:0] req_x0,
    input  logic [WIDTH-1:0] req_x1,
    input  logic [WIDTH-1:0] req_y0,
    input  logic [WIDTH-1:0] req_y1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_c,
    output logic             rsp_zero,
    output logic             rsp_of,
    output logic [2:0]       alu_op,
    output logic             alu_c,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    input  logic [WIDTH-1:0] alu_s,
    input  logic             alu_cout,
    input  logic             alu_zero,
    input  logic             alu_of
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t           r_state;
    logic             r_last;
    logic             r_owner;
    logic [3:0]       r_cnt;
    logic [1:0]       r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_s;
    logic             r_rsp_c;
    logic             r_rsp_zero;
    logic             r_rsp_of;
    logic [2:0]       r_alu_op;
    logic             r_alu_c;
    logic [WIDTH-1:0] r_alu_x;
    logic [WIDTH-1:0] r_alu_y;

    logic             w_gnt_any;
    logic             w_gnt_idx;
    logic [1:0]       w_req_ready;
    logic             w_accept;
    logic [2:0]       w_op;
    logic             w_c;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;

    // Round-robin grant: a lone requester wins, contention goes to the port
    // that was not served last. Ready is suppressed while reset is asserted.
    always_comb begin
        w_gnt_any   = 1'b0;
        w_gnt_idx   = 1'b0;
        w_req_ready = '0;
        case (req_valid)
            2'b01:   begin w_gnt_any = 1'b1; w_gnt_idx = 1'b0;    end
            2'b10:   begin w_gnt_any = 1'b1; w_gnt_idx = 1'b1;    end
            2'b11:   begin w_gnt_any = 1'b1; w_gnt_idx = ~r_last; end
            default: begin w_gnt_any = 1'b0; w_gnt_idx = 1'b0;    end
        endcase
        if (r_state == IDLE && w_gnt_any && !rst) begin
            w_req_ready[w_gnt_idx] = 1'b1;
        end
        w_accept = |(req_valid & w_req_ready);
    end

    // Operand mux selecting the granted port's request fields.
    always_comb begin
        w_op = w_gnt_idx ? req_op1 : req_op0;
        w_c  = w_gnt_idx ? req_c1  : req_c0;
        w_x  = w_gnt_idx ? req_x1  : req_x0;
        w_y  = w_gnt_idx ? req_y1  : req_y0;
    end

    // Sequencer FSM: launch, settle countdown, result capture and response hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_cnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_s     <= '0;
            r_rsp_c     <= 1'b0;
            r_rsp_zero  <= 1'b0;
            r_rsp_of    <= 1'b0;
            r_alu_op    <= '0;
            r_alu_c     <= 1'b0;
            r_alu_x     <= '0;
            r_alu_y     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_alu_op <= w_op;
                        r_alu_c  <= w_c;
                        r_alu_x  <= w_x;
                        r_alu_y  <= w_y;
                        r_owner  <= w_gnt_idx;
                        r_last   <= w_gnt_idx;
                        r_cnt    <= SETTLE_LOAD;
                        r_state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_s     <= alu_s;
                        r_rsp_c     <= alu_cout;
                        r_rsp_zero  <= alu_zero;
                        r_rsp_of    <= alu_of;
                        r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready[r_owner]) begin
                        r_rsp_valid <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= '0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_s     = r_rsp_s;
    assign rsp_c     = r_rsp_c;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_of    = r_rsp_of;
    assign alu_op    = r_alu_op;
    assign alu_c     = r_alu_c;
    assign alu_x     = r_alu_x;
    assign alu_y     = r_alu_y;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: SETTLE=1 instance for most scenarios, SETTLE=4
// instance for the settle-time scenario. Each instance drives a behavioural
// 4-bit ALU; expected responses are queued at accept and checked on output.
module tb_alu_arbiter;

    logic       clk;
    logic       rst;

    // SETTLE=1 instance signals
    logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [2:0] req_op0, req_op1, alu_op;
    logic       req_c0, req_c1, rsp_c, rsp_zero, rsp_of, alu_c, alu_cout, alu_zero, alu_of;
    logic [3:0] req_x0, req_x1, req_y0, req_y1, rsp_s, alu_x, alu_y, alu_s;

    // SETTLE=4 instance signals
    logic [1:0] d4_req_valid, d4_req_ready, d4_rsp_valid, d4_rsp_ready;
    logic [2:0] d4_req_op0, d4_req_op1, d4_alu_op;
    logic       d4_req_c0, d4_req_c1, d4_rsp_c, d4_rsp_zero, d4_rsp_of, d4_alu_c;
    logic       d4_alu_cout, d4_alu_zero, d4_alu_of;
    logic [3:0] d4_req_x0, d4_req_x1, d4_req_y0, d4_req_y1, d4_rsp_s;
    logic [3:0] d4_alu_x, d4_alu_y, d4_alu_s;

    int vectors     = 0;
    int miscompares = 0;
    logic model_last;

    typedef struct packed {
        logic       port;
        logic [6:0] d;     // {s[3:0], cout, zero, of}
    } exp_t;

    exp_t sb[$];
    exp_t sb4[$];

    // Reference ALU: {s, cout, zero, of}
    function automatic logic [6:0] alu_ref(input logic [2:0] op, input logic c,
                                           input logic [3:0] x, input logic [3:0] y);
        logic [4:0] sum;
        logic [3:0] s;
        logic       co, of;
        case (op)
            3'b000: begin
                sum = {1'b0, x} + {1'b0, y} + {4'b0000, c};
                s   = sum[3:0];
                co  = sum[4];
                of  = (x[3] == y[3]) && (s[3] != x[3]);
            end
            default: begin
                s  = x ^ y;
                co = 1'b0;
                of = 1'b0;
            end
        endcase
        return {s, co, (s == 4'd0), of};
    endfunction

    assign {alu_s, alu_cout, alu_zero, alu_of}             = alu_ref(alu_op, alu_c, alu_x, alu_y);
    assign {d4_alu_s, d4_alu_cout, d4_alu_zero, d4_alu_of} = alu_ref(d4_alu_op, d4_alu_c, d4_alu_x, d4_alu_y);

    alu_arbiter #(.WIDTH(4), .SETTLE(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1), .req_c0(req_c0), .req_c1(req_c1),
        .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_s(rsp_s), .rsp_c(rsp_c), .rsp_zero(rsp_zero), .rsp_of(rsp_of),
        .alu_op(alu_op), .alu_c(alu_c), .alu_x(alu_x), .alu_y(alu_y),
        .alu_s(alu_s), .alu_cout(alu_cout), .alu_zero(alu_zero), .alu_of(alu_of)
    );

    alu_arbiter #(.WIDTH(4), .SETTLE(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .req_valid(d4_req_valid), .req_ready(d4_req_ready),
        .req_op0(d4_req_op0), .req_op1(d4_req_op1), .req_c0(d4_req_c0), .req_c1(d4_req_c1),
        .req_x0(d4_req_x0), .req_x1(d4_req_x1), .req_y0(d4_req_y0), .req_y1(d4_req_y1),
        .rsp_valid(d4_rsp_valid), .rsp_ready(d4_rsp_ready),
        .rsp_s(d4_rsp_s), .rsp_c(d4_rsp_c), .rsp_zero(d4_rsp_zero), .rsp_of(d4_rsp_of),
        .alu_op(d4_alu_op), .alu_c(d4_alu_c), .alu_x(d4_alu_x), .alu_y(d4_alu_y),
        .alu_s(d4_alu_s), .alu_cout(d4_alu_cout), .alu_zero(d4_alu_zero), .alu_of(d4_alu_of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits (bounded) for an accept on the SETTLE=1 instance; returns just after the accept edge.
    task automatic wait_accept(input int limit, output logic port, output bit ok);
        ok   = 1'b0;
        port = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != 2'b00) begin
                port = req_ready[1];
                ok   = 1'b1;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits (bounded) until a response is presented; returns at that negedge.
    task automatic wait_rsp(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) ok = 1'b1;
        end
    endtask

    task automatic push_exp(input logic port, input logic [6:0] d);
        exp_t e;
        e.port = port;
        e.d    = d;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({req_ready, rsp_valid, rsp_s, rsp_c, rsp_zero, rsp_of, alu_op, alu_c, alu_x, alu_y} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_state got %h want 0", {req_ready, rsp_valid, rsp_s, rsp_c, rsp_zero, rsp_of, alu_op, alu_c, alu_x, alu_y});
        end
        vectors++;
        if ({d4_req_ready, d4_rsp_valid, d4_rsp_s, d4_alu_x, d4_alu_y} !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_state_s4 got %h want 0", {d4_req_ready, d4_rsp_valid, d4_rsp_s, d4_alu_x, d4_alu_y});
        end
        @(posedge clk);
        #1;
        rst        = 1'b0;
        model_last = 1'b1;
    endtask

    task automatic test_single();
        logic p;
        bit   ok;
        exp_t e;
        req_op0 = 3'b000; req_c0 = 1'b0; req_x0 = 4'd3; req_y0 = 4'd4;
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        wait_accept(10, p, ok);
        req_valid = 2'b00;
        vectors++;
        if (!ok || p !== 1'b0) begin
            miscompares++;
            $display("FAIL single_grant got ok=%0d port=%0d want ok=1 port=0", ok, p);
        end
        push_exp(1'b0, {4'd7, 1'b0, 1'b0, 1'b0});
        model_last = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rsp_valid, alu_op, alu_c, alu_x, alu_y} !== {2'b00, 3'b000, 1'b0, 4'd3, 4'd4}) begin
            miscompares++;
            $display("FAIL single_exec got %h want %h", {rsp_valid, alu_op, alu_c, alu_x, alu_y}, {2'b00, 3'b000, 1'b0, 4'd3, 4'd4});
        end
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (rsp_valid !== 2'b01) begin
            miscompares++;
            $display("FAIL single_rsp_valid got %b want 01", rsp_valid);
        end
        vectors++;
        if ({rsp_s, rsp_c, rsp_zero, rsp_of} !== e.d) begin
            miscompares++;
            $display("FAIL single_data got %h want %h", {rsp_s, rsp_c, rsp_zero, rsp_of}, e.d);
        end
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL single_rsp_drop got %b want 00", rsp_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_settle();
        bit   ok;
        exp_t e;
        d4_req_op0 = 3'b000; d4_req_c0 = 1'b0; d4_req_x0 = 4'd5; d4_req_y0 = 4'd5;
        d4_rsp_ready = 2'b11;
        d4_req_valid = 2'b01;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (d4_req_ready == 2'b01) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        d4_req_valid = 2'b00;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL settle_accept got no accept want accept within 10 cycles");
        end
        e.port = 1'b0;
        e.d    = {4'hA, 1'b0, 1'b0, 1'b1};
        sb4.push_back(e);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if ({d4_rsp_valid, d4_alu_x, d4_alu_y} !== {2'b00, 4'd5, 4'd5}) begin
                miscompares++;
                $display("FAIL settle_exec cycle %0d got %h want %h", k, {d4_rsp_valid, d4_alu_x, d4_alu_y}, {2'b00, 4'd5, 4'd5});
            end
        end
        @(negedge clk);
        e = sb4.pop_front();
        vectors++;
        if ({d4_rsp_valid, d4_rsp_s, d4_rsp_c, d4_rsp_zero, d4_rsp_of} !== {2'b01, e.d}) begin
            miscompares++;
            $display("FAIL settle_rsp got %h want %h", {d4_rsp_valid, d4_rsp_s, d4_rsp_c, d4_rsp_zero, d4_rsp_of}, {2'b01, e.d});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_contention();
        logic       p, want_p;
        bit         ok;
        exp_t       e;
        logic [1:0] want_v;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_last = 1'b1;
        sb.delete();
        req_op0 = 3'b000; req_c0 = 1'b0; req_x0 = 4'd7; req_y0 = 4'd1;
        req_op1 = 3'b000; req_c1 = 1'b0; req_x1 = 4'd8; req_y1 = 4'd8;
        rsp_ready = 2'b11;
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            want_p = ~model_last;
            wait_accept(10, p, ok);
            vectors++;
            if (!ok || p !== want_p) begin
                miscompares++;
                $display("FAIL contention_grant %0d got ok=%0d port=%0d want port=%0d", n, ok, p, want_p);
            end
            model_last = want_p;
            push_exp(want_p, want_p ? {4'd0, 1'b1, 1'b1, 1'b1} : {4'd8, 1'b0, 1'b0, 1'b1});
            wait_rsp(10, ok);
            if (n == 3) req_valid = 2'b00;
            e = sb.pop_front();
            want_v = '0;
            want_v[e.port] = 1'b1;
            vectors++;
            if (!ok || rsp_valid !== want_v) begin
                miscompares++;
                $display("FAIL contention_rsp_valid %0d got %b want %b", n, rsp_valid, want_v);
            end
            vectors++;
            if ({rsp_s, rsp_c, rsp_zero, rsp_of} !== e.d) begin
                miscompares++;
                $display("FAIL contention_data %0d got %h want %h", n, {rsp_s, rsp_c, rsp_zero, rsp_of}, e.d);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic p;
        bit   ok;
        exp_t e;
        req_op1 = 3'b000; req_c1 = 1'b0; req_x1 = 4'd2; req_y1 = 4'd2;
        req_op0 = 3'b000; req_c0 = 1'b0; req_x0 = 4'd1; req_y0 = 4'd1;
        rsp_ready = 2'b01;
        req_valid = 2'b10;
        wait_accept(10, p, ok);
        req_valid = 2'b01;
        vectors++;
        if (!ok || p !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_grant got ok=%0d port=%0d want port=1", ok, p);
        end
        model_last = 1'b1;
        push_exp(1'b1, {4'd4, 1'b0, 1'b0, 1'b0});
        wait_rsp(10, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || {rsp_valid, rsp_s, rsp_c, rsp_zero, rsp_of} !== {2'b10, e.d}) begin
            miscompares++;
            $display("FAIL bp_rsp got %h want %h", {rsp_valid, rsp_s, rsp_c, rsp_zero, rsp_of}, {2'b10, e.d});
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if ({rsp_valid, rsp_s, req_ready} !== {2'b10, 4'd4, 2'b00}) begin
                miscompares++;
                $display("FAIL bp_stall cycle %0d got %h want %h", k, {rsp_valid, rsp_s, req_ready}, {2'b10, 4'd4, 2'b00});
            end
        end
        @(posedge clk);
        #1;
        rsp_ready = 2'b11;
        @(negedge clk);
        vectors++;
        if ({rsp_valid, req_ready} !== {2'b10, 2'b00}) begin
            miscompares++;
            $display("FAIL bp_release got %b want 1000", {rsp_valid, req_ready});
        end
        @(negedge clk);
        vectors++;
        if ({rsp_valid, req_ready} !== {2'b00, 2'b01}) begin
            miscompares++;
            $display("FAIL bp_next_grant got %b want 0001", {rsp_valid, req_ready});
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        model_last = 1'b0;
        push_exp(1'b0, {4'd2, 1'b0, 1'b0, 1'b0});
        wait_rsp(10, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || {rsp_valid, rsp_s, rsp_c, rsp_zero, rsp_of} !== {2'b01, e.d}) begin
            miscompares++;
            $display("FAIL bp_port0_rsp got %h want %h", {rsp_valid, rsp_s, rsp_c, rsp_zero, rsp_of}, {2'b01, e.d});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop();
        logic p;
        bit   ok;
        exp_t e;
        req_op0 = 3'b000; req_c0 = 1'b0; req_x0 = 4'd3; req_y0 = 4'd4;
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        wait_accept(10, p, ok);
        req_valid = 2'b00;
        rst = 1'b1;
        #1;
        vectors++;
        if ({rsp_valid, alu_x, rsp_s, req_ready} !== 12'd0) begin
            miscompares++;
            $display("FAIL midop_reset got %h want 0", {rsp_valid, alu_x, rsp_s, req_ready});
        end
        model_last = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_op0 = 3'b000; req_c0 = 1'b0; req_x0 = 4'd1; req_y0 = 4'd2;
        req_op1 = 3'b000; req_c1 = 1'b0; req_x1 = 4'd3; req_y1 = 4'd3;
        req_valid = 2'b11;
        wait_accept(10, p, ok);
        req_valid = 2'b00;
        vectors++;
        if (!ok || p !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_first_grant got ok=%0d port=%0d want port=0", ok, p);
        end
        model_last = 1'b0;
        push_exp(1'b0, alu_ref(3'b000, 1'b0, 4'd1, 4'd2));
        wait_rsp(10, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || {rsp_valid, rsp_s, rsp_c, rsp_zero, rsp_of} !== {2'b01, e.d}) begin
            miscompares++;
            $display("FAIL midop_rsp got %h want %h", {rsp_valid, rsp_s, rsp_c, rsp_zero, rsp_of}, {2'b01, e.d});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sweep();
        logic       p, c;
        bit         ok;
        int         stall;
        exp_t       e;
        logic [1:0] want_v;
        logic [3:0] xv, yv;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                xv    = 4'(x);
                yv    = 4'(y);
                p     = 1'($urandom_range(0, 1));
                c     = 1'($urandom_range(0, 1));
                stall = $urandom_range(0, 2);
                if (p) begin
                    req_op1 = 3'b000; req_c1 = c; req_x1 = xv; req_y1 = yv;
                    req_op0 = 3'b000; req_c0 = ~c; req_x0 = ~xv; req_y0 = yv;
                end else begin
                    req_op0 = 3'b000; req_c0 = c; req_x0 = xv; req_y0 = yv;
                    req_op1 = 3'b000; req_c1 = ~c; req_x1 = ~xv; req_y1 = yv;
                end
                rsp_ready    = 2'(($urandom_range(0, 1)) << (~p));
                rsp_ready[p] = (stall == 0);
                req_valid    = p ? 2'b10 : 2'b01;
                wait_accept(10, e.port, ok);
                req_valid = 2'b00;
                vectors++;
                if (!ok || e.port !== p) begin
                    miscompares++;
                    $display("FAIL sweep_grant x=%0d y=%0d got port=%0d want %0d", x, y, e.port, p);
                end
                model_last = p;
                push_exp(p, alu_ref(3'b000, c, xv, yv));
                wait_rsp(10, ok);
                e = sb.pop_front();
                want_v = '0;
                want_v[e.port] = 1'b1;
                vectors++;
                if (!ok || rsp_valid !== want_v) begin
                    miscompares++;
                    $display("FAIL sweep_port x=%0d y=%0d got %b want %b", x, y, rsp_valid, want_v);
                end
                vectors++;
                if ({rsp_s, rsp_c, rsp_zero, rsp_of} !== e.d) begin
                    miscompares++;
                    $display("FAIL sweep_data x=%0d y=%0d c=%0d got %h want %h", x, y, c, {rsp_s, rsp_c, rsp_zero, rsp_of}, e.d);
                end
                if (stall > 0) begin
                    repeat (stall) begin
                        @(posedge clk);
                        #1;
                    end
                    rsp_ready[p] = 1'b1;
                    @(negedge clk);
                    vectors++;
                    if ({rsp_valid, rsp_s, rsp_c, rsp_zero, rsp_of} !== {want_v, e.d}) begin
                        miscompares++;
                        $display("FAIL sweep_hold x=%0d y=%0d got %h want %h", x, y, {rsp_valid, rsp_s, rsp_c, rsp_zero, rsp_of}, {want_v, e.d});
                    end
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; rsp_ready = '0;
        req_op0 = '0; req_op1 = '0; req_c0 = 1'b0; req_c1 = 1'b0;
        req_x0 = '0; req_x1 = '0; req_y0 = '0; req_y1 = '0;
        d4_req_valid = '0; d4_rsp_ready = '0;
        d4_req_op0 = '0; d4_req_op1 = '0; d4_req_c0 = 1'b0; d4_req_c1 = 1'b0;
        d4_req_x0 = '0; d4_req_x1 = '0; d4_req_y0 = '0; d4_req_y1 = '0;
        model_last = 1'b1;

        test_reset();
        test_single();
        test_settle();
        test_contention();
        test_backpressure();
        test_reset_midop();
        test_sweep();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
